// File: rtl/rc4_stream_cipher.sv
// Keystream consumer: latches key, runs one core block, XORs a byte stream against it.
// Latency: 1 clk din->dout once the keystream block is captured; 1 byte/clk sustained.
// Backpressure: din_ready drops while a held dout byte is not taken or the block is spent.
module rc4_stream_cipher #(
    parameter int NUMS_OF_BYTES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_start,
    input  logic [NUMS_OF_BYTES*8-1:0] cfg_key,
    input  logic [7:0]                 cfg_key_length,
    input  logic [7:0]                 cfg_msg_len,
    output logic                       core_start,
    output logic [NUMS_OF_BYTES*8-1:0] core_key,
    output logic [7:0]                 core_key_length,
    input  logic [NUMS_OF_BYTES*8-1:0] core_data,
    input  logic                       core_done,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic [7:0]                 din_data,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [7:0]                 dout_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam logic [7:0] NB = 8'(NUMS_OF_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_STREAM
    } state_t;

    state_t                     state_q;
    logic                       core_start_q;
    logic [NUMS_OF_BYTES*8-1:0] core_key_q;
    logic [7:0]                 core_key_length_q;
    logic [NUMS_OF_BYTES*8-1:0] ks_q;
    logic [7:0]                 len_q;
    logic [7:0]                 idx_q;
    logic                       core_done_q;
    logic                       dout_valid_q;
    logic [7:0]                 dout_data_q;
    logic                       done_q;
    logic                       err_q;

    logic [7:0] ks_byte;
    logic       din_accept;

    always_comb begin
        ks_byte = 8'h00;
        for (int k = 0; k < NUMS_OF_BYTES; k++) begin
            if (idx_q == 8'(k)) begin
                ks_byte = ks_q[k*8 +: 8];
            end
        end
    end

    assign din_ready  = (state_q == ST_STREAM) && (idx_q < len_q) && (!dout_valid_q || dout_ready);
    assign din_accept = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            core_start_q      <= 1'b0;
            core_key_q        <= '0;
            core_key_length_q <= 8'h00;
            ks_q              <= '0;
            len_q             <= 8'h00;
            idx_q             <= 8'h00;
            core_done_q       <= 1'b0;
            dout_valid_q      <= 1'b0;
            dout_data_q       <= 8'h00;
            done_q            <= 1'b0;
            err_q             <= 1'b0;
        end else begin
            // Tracking core_done every cycle means a level already high on entering WAIT is no edge.
            core_done_q <= core_done;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        core_key_q        <= cfg_key;
                        core_key_length_q <= cfg_key_length;
                        len_q             <= (cfg_msg_len > NB) ? NB : cfg_msg_len;
                        err_q             <= (cfg_msg_len > NB);
                        state_q           <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    core_start_q <= 1'b1;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done && !core_done_q) begin
                        ks_q         <= core_data;
                        core_start_q <= 1'b0;
                        idx_q        <= 8'h00;
                        state_q      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (din_accept) begin
                        dout_data_q  <= din_data ^ ks_byte;
                        dout_valid_q <= 1'b1;
                        idx_q        <= idx_q + 8'd1;
                    end else if (dout_valid_q && dout_ready) begin
                        dout_valid_q <= 1'b0;
                    end
                    if ((idx_q == len_q) && !dout_valid_q) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_start      = core_start_q;
    assign core_key        = core_key_q;
    assign core_key_length = core_key_length_q;
    assign dout_valid      = dout_valid_q;
    assign dout_data       = dout_data_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign err             = err_q;

endmodule

// File: tb/tb_rc4_stream_cipher.sv
// Directed bench for rc4_stream_cipher; the bench plays the keystream core for key "Key".
module tb_rc4_stream_cipher;
    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cfg_start;
    logic [N*8-1:0] cfg_key;
    logic [7:0]     cfg_key_length;
    logic [7:0]     cfg_msg_len;
    logic           core_start;
    logic [N*8-1:0] core_key;
    logic [7:0]     core_key_length;
    logic [N*8-1:0] core_data;
    logic           core_done;
    logic           din_valid;
    logic           din_ready;
    logic [7:0]     din_data;
    logic           dout_valid;
    logic           dout_ready;
    logic [7:0]     dout_data;
    logic           busy;
    logic           done;
    logic           err;

    always #5 clk = ~clk;

    rc4_stream_cipher #(.NUMS_OF_BYTES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_key(cfg_key), .cfg_key_length(cfg_key_length),
        .cfg_msg_len(cfg_msg_len),
        .core_start(core_start), .core_key(core_key), .core_key_length(core_key_length),
        .core_data(core_data), .core_done(core_done),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .busy(busy), .done(done), .err(err)
    );

    // RC4 keystream of key "Key" (4B 65 79), first 16 bytes.
    logic [7:0] ks [16] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72,
                            8'hA7, 8'h19, 8'h4A, 8'h28, 8'h67, 8'hB6, 8'h42, 8'h95};
    logic [7:0] pt [9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    logic [N*8-1:0] ks_flat;
    logic [N*8-1:0] key_flat;
    logic [7:0]     tb_in  [20];
    logic [7:0]     tb_exp [20];
    int             checks   = 0;
    int             failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_case1();
        for (int i = 0; i < 9; i++) begin
            tb_in[i]  = pt[i];
            tb_exp[i] = ct[i];
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_core_start"}, 128'(core_start), 128'(0));
        chk({tag, "_core_key"}, core_key, 128'(0));
        chk({tag, "_core_keylen"}, 128'(core_key_length), 128'(0));
        chk({tag, "_din_ready"}, 128'(din_ready), 128'(0));
        chk({tag, "_dout_valid"}, 128'(dout_valid), 128'(0));
        chk({tag, "_dout_data"}, 128'(dout_data), 128'(0));
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_err"}, 128'(err), 128'(0));
    endtask

    task automatic run_msg(input string tag, input logic [7:0] mlen, input int n_in, input int n_exp,
                           input bit exp_err, input bit stall_mode, input int abort_at,
                           input bit mid_start);
        int         in_i = 0;
        int         out_i = 0;
        int         dones = 0;
        int         cyc = 0;
        bit         got = 0;
        bit         prev_stall = 0;
        bit         rdy_checked = 0;
        logic [7:0] prev_data = 8'h00;

        @(negedge clk);
        cfg_key = key_flat; cfg_key_length = 8'd3; cfg_msg_len = mlen; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (core_start) got = 1;
            else @(negedge clk);
        end
        chk({tag, "_core_start"}, 128'(got), 128'(1));
        chk({tag, "_core_key"}, core_key, key_flat);
        chk({tag, "_core_keylen"}, 128'(core_key_length), 128'(3));
        chk({tag, "_err"}, 128'(err), 128'(exp_err));
        chk({tag, "_busy"}, 128'(busy), 128'(1));
        repeat (2) @(negedge clk);
        core_data = ks_flat;
        core_done = 1'b1;

        while (dones == 0 && cyc < 300 && !(abort_at > 0 && out_i == abort_at)) begin
            @(negedge clk);
            cyc++;
            if (!core_start) core_done = 1'b0;
            dout_ready = stall_mode ? (cyc % 2 == 0) : 1'b1;
            din_valid  = (in_i < n_in) && (!stall_mode || (cyc % 3 != 2));
            din_data   = tb_in[(in_i < 20) ? in_i : 0];
            if (mid_start && cyc == 4) begin
                cfg_start = 1'b1; cfg_msg_len = 8'd5; cfg_key = '0; cfg_key_length = 8'd7;
            end else begin
                cfg_start = 1'b0;
            end
            #1;
            if (done) dones++;
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, 128'(dout_valid), 128'(1));
                chk({tag, "_hold_data"}, 128'(dout_data), 128'(prev_data));
            end
            if (dout_valid && dout_ready) begin
                chk({tag, "_no_extra"}, 128'(out_i < n_exp), 128'(1));
                if (out_i < n_exp) chk({tag, "_byte"}, 128'(dout_data), 128'(tb_exp[out_i]));
                out_i++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_data  = dout_data;
            if (in_i >= n_exp && in_i < n_in && !rdy_checked && busy) begin
                chk({tag, "_din_ready_spent"}, 128'(din_ready), 128'(0));
                rdy_checked = 1;
            end
            if (din_valid && din_ready) in_i++;
        end
        cfg_start  = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        if (abort_at > 0) return;

        chk({tag, "_done_seen"}, 128'(dones), 128'(1));
        chk({tag, "_out_count"}, 128'(out_i), 128'(n_exp));
        if (mid_start) begin
            chk({tag, "_key_kept"}, core_key, key_flat);
            chk({tag, "_keylen_kept"}, 128'(core_key_length), 128'(3));
        end
        @(negedge clk);
        chk({tag, "_done_pulse"}, 128'(done), 128'(0));
        chk({tag, "_idle"}, 128'(busy), 128'(0));
        chk({tag, "_err_sticky"}, 128'(err), 128'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ks_flat[i*8 +: 8] = ks[i];
        key_flat = '0;
        key_flat[23:0] = {8'h79, 8'h65, 8'h4B};

        rst_n = 1'b0; cfg_start = 1'b0; cfg_key = '0; cfg_key_length = 8'h00; cfg_msg_len = 8'h00;
        core_data = '0; core_done = 1'b0; din_valid = 1'b0; din_data = 8'h00; dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst_n = 1'b1;

        // Encrypt, then decrypt the ciphertext back.
        load_case1();
        run_msg("enc", 8'd3 + 8'd6, 9, 9, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            tb_in[i]  = ct[i];
            tb_exp[i] = pt[i];
        end
        run_msg("dec", 8'd9, 9, 9, 1'b0, 1'b0, 0, 1'b0);

        load_case1();
        run_msg("stall", 8'd9, 9, 9, 1'b0, 1'b1, 0, 1'b0);

        // Oversized message: clamp to one keystream block.
        for (int i = 0; i < 20; i++) begin
            tb_in[i]  = 8'(i);
            tb_exp[i] = (i < 16) ? (ks[i] ^ 8'(i)) : 8'h00;
        end
        run_msg("long", 8'd20, 20, 16, 1'b1, 1'b0, 0, 1'b0);
        run_msg("empty", 8'd0, 0, 0, 1'b0, 1'b0, 0, 1'b0);

        // Reset mid-message after four output bytes.
        load_case1();
        run_msg("abort", 8'd9, 9, 9, 1'b0, 1'b0, 4, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_zero("midrst");
        rst_n = 1'b1;
        core_done = 1'b0;
        run_msg("after_rst", 8'd9, 9, 9, 1'b0, 1'b0, 0, 1'b0);

        run_msg("midstart", 8'd9, 9, 9, 1'b0, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
